// File: rtl/z80tube_pkg.sv
// Shared definitions for the host I/O blocks in the &FC10-&FC1F window:
// PMOD register offsets, SPI_CTRL/status bit positions, pin roles and the
// SPI engine state encoding.
package z80tube_pkg;

  // Register offsets within the &FC18-&FC1F window (ADR[3:0]).
  localparam logic [3:0] REG_SPI_DATA = 4'h8;
  localparam logic [3:0] REG_SPI_CTRL = 4'h9;
  localparam logic [3:0] REG_DIR      = 4'hE;
  localparam logic [3:0] REG_DATA     = 4'hF;

  // SPI_CTRL writable fields.
  localparam int CTRL_DIV_LSB = 0;
  localparam int CTRL_SPI_EN  = 2;
  localparam int CTRL_CS      = 3;
  localparam int CTRL_IE      = 4;

  // SPI_CTRL read-only status bits.
  localparam int STAT_OVR  = 5;
  localparam int STAT_DONE = 6;
  localparam int STAT_BUSY = 7;

  // PMOD pin roles while the SPI master owns pins 0-3.
  localparam int PIN_SCK  = 0;
  localparam int PIN_MOSI = 1;
  localparam int PIN_MISO = 2;
  localparam int PIN_CS   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } spi_state_e;

  // Last divider count of a half SCK period: a half period lasts 2^div cycles.
  function automatic logic [2:0] half_period_last(input logic [1:0] div);
    return 3'((1 << div) - 1);
  endfunction

endpackage

// File: rtl/pmod_spi_engine.sv
// Byte-wide SPI master, mode 0, MSB first. A transfer is 16 half periods of
// 2^div clock cycles each; MISO is sampled on every SCK rise and MOSI
// advances on every SCK fall. abort forces IDLE immediately.
module pmod_spi_engine
  import z80tube_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [1:0] div,
  input  logic       abort,
  input  logic       miso,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rx,
  output logic       sck,
  output logic       mosi,
  output spi_state_e state
);

  spi_state_e state_q, state_d;
  logic [1:0] div_q;
  logic [2:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic [7:0] rx_q;
  logic       half_end;
  logic       load;
  logic       rise;
  logic       fall;

  assign half_end = (cnt_q == half_period_last(div_q));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-cycle load/rise/fall actions; abort overrides all.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LO;
          load    = 1'b1;
        end
      end
      ST_LO: begin
        if (half_end) begin
          state_d = ST_HI;
          rise    = 1'b1;
        end
      end
      ST_HI: begin
        if (half_end) begin
          fall = 1'b1;
          if (bit_q == 3'd7) begin
            state_d    = ST_IDLE;
            done_pulse = 1'b1;
          end else begin
            state_d = ST_LO;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d    = ST_IDLE;
      load       = 1'b0;
      rise       = 1'b0;
      fall       = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // Divider, bit counter and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 2'd0;
      cnt_q   <= 3'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rx_q    <= 8'h00;
    end else if (load) begin
      div_q   <= div;
      cnt_q   <= 3'd0;
      bit_q   <= 3'd0;
      shift_q <= din;
    end else if (state_q != ST_IDLE) begin
      cnt_q <= half_end ? 3'd0 : cnt_q + 3'd1;
      if (rise) begin
        rx_q <= {rx_q[6:0], miso};
      end
      if (fall) begin
        shift_q <= {shift_q[6:0], 1'b0};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign sck   = (state_q == ST_HI);
  assign mosi  = shift_q[7];
  assign rx    = rx_q;
  assign state = state_q;

endmodule

// File: rtl/pmod_port.sv
// PMOD expansion-port controller at &FC18-&FC1F: 8-bit GPIO with per-pin
// direction plus an SPI master that takes over pins 0-3 when enabled.
//
// Bus access semantics: wr_act/rd_act are the qualified Z80 I/O cycle terms.
// A strobe fires for exactly one clock, on the first edge where the term is
// high and its registered copy is low, so wait-stretched cycles act once.
// DOUT/DOUT_EN are combinational for the whole read cycle.
module pmod_port
  import z80tube_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       SEL,
  input  logic [3:0] ADR,
  input  logic       IOREQ_B,
  input  logic       RD_B,
  input  logic       WR_B,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOUT_EN,
  inout  wire  [7:0] PMOD_GPIO,
  output logic       INT_B
);

  logic       wr_act, rd_act;
  logic       wr_act_q, rd_act_q;
  logic       wr_stb, rd_stb;
  logic       wr_spi_data, wr_ctrl, wr_dir, wr_data;
  logic       rd_spi_data, rd_ctrl;
  logic [4:0] ctrl_q;
  logic [7:0] dir_q, data_q;
  logic [7:0] rx_data_q;
  logic       done_q, ovr_q;
  logic [7:0] sync1_q, sync2_q;
  logic       spi_en;
  logic       spi_start, spi_abort, spi_busy, spi_done, spi_sck, spi_mosi;
  logic [7:0] spi_rx;
  spi_state_e spi_state;
  logic [7:0] pin_oe, pin_out;
  logic [7:0] status;

  assign wr_act = SEL & ADR[3] & ~IOREQ_B & ~WR_B;
  assign rd_act = SEL & ADR[3] & ~IOREQ_B & ~RD_B;
  assign wr_stb = wr_act & ~wr_act_q;
  assign rd_stb = rd_act & ~rd_act_q;

  assign wr_spi_data = wr_stb && (ADR == REG_SPI_DATA);
  assign wr_ctrl     = wr_stb && (ADR == REG_SPI_CTRL);
  assign wr_dir      = wr_stb && (ADR == REG_DIR);
  assign wr_data     = wr_stb && (ADR == REG_DATA);
  assign rd_spi_data = rd_stb && (ADR == REG_SPI_DATA);
  assign rd_ctrl     = rd_stb && (ADR == REG_SPI_CTRL);

  assign spi_en = ctrl_q[CTRL_SPI_EN];

  // A transfer only starts from IDLE with the master enabled; clearing
  // SPI_EN aborts on the same edge the control write lands.
  assign spi_start = wr_spi_data && spi_en && (spi_state == ST_IDLE);
  assign spi_abort = wr_ctrl ? ~DIN[CTRL_SPI_EN] : ~spi_en;

  // Registered copies of the access terms for the strobe edge detect.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
    end
  end

  // Host-visible registers and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ctrl_q    <= 5'h00;
      dir_q     <= 8'h00;
      data_q    <= 8'h00;
      rx_data_q <= 8'h00;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= DIN[4:0];
      if (wr_dir)  dir_q  <= DIN;
      if (wr_data) data_q <= DIN;
      if (spi_done) begin
        done_q    <= 1'b1;
        rx_data_q <= spi_rx;
      end else if (rd_spi_data) begin
        done_q <= 1'b0;
      end
      if (wr_spi_data && spi_busy) begin
        ovr_q <= 1'b1;
      end else if (rd_ctrl) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Two-flop synchroniser for the GPIO input path.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= PMOD_GPIO;
      sync2_q <= sync1_q;
    end
  end

  pmod_spi_engine u_engine (
    .clk        (CLK),
    .rst_n      (RESET_B),
    .start      (spi_start),
    .din        (DIN),
    .div        (ctrl_q[CTRL_DIV_LSB +: 2]),
    .abort      (spi_abort),
    .miso       (PMOD_GPIO[PIN_MISO]),
    .busy       (spi_busy),
    .done_pulse (spi_done),
    .rx         (spi_rx),
    .sck        (spi_sck),
    .mosi       (spi_mosi),
    .state      (spi_state)
  );

  // Pin ownership: GPIO by default, SPI roles on pins 0-3 when enabled.
  always_comb begin
    pin_oe  = dir_q;
    pin_out = data_q;
    if (spi_en) begin
      pin_oe[PIN_SCK]   = 1'b1;
      pin_out[PIN_SCK]  = spi_sck;
      pin_oe[PIN_MOSI]  = 1'b1;
      pin_out[PIN_MOSI] = spi_mosi;
      pin_oe[PIN_MISO]  = 1'b0;
      pin_out[PIN_MISO] = 1'b0;
      pin_oe[PIN_CS]    = 1'b1;
      pin_out[PIN_CS]   = ~ctrl_q[CTRL_CS];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_pin
    assign PMOD_GPIO[i] = pin_oe[i] ? pin_out[i] : 1'bz;
  end

  // Status view of SPI_CTRL.
  always_comb begin
    status            = {3'b000, ctrl_q};
    status[STAT_BUSY] = spi_busy;
    status[STAT_DONE] = done_q;
    status[STAT_OVR]  = ovr_q;
  end

  // Read data mux, live for the whole read cycle.
  always_comb begin
    DOUT = 8'h00;
    if (rd_act) begin
      case (ADR)
        REG_SPI_DATA: DOUT = rx_data_q;
        REG_SPI_CTRL: DOUT = status;
        REG_DIR:      DOUT = dir_q;
        REG_DATA:     DOUT = sync2_q;
        default:      DOUT = 8'h00;
      endcase
    end
  end

  assign DOUT_EN = rd_act;
  assign INT_B   = ~(done_q & ctrl_q[CTRL_IE]);

endmodule

// File: doc/pmod_port.md
# pmod_port

PMOD expansion-port controller occupying host I/O ports &FC18–&FC1F, alongside the Tube window at &FC10–&FC17. It consumes Z80 I/O read/write cycles already qualified by the upper-address decode, and provides an 8-bit GPIO with per-pin direction. It also provides a byte-wide SPI master (mode 0, MSB first) that takes over PMOD pins 0–3 when enabled, plus a completion interrupt to the host.

## Interface
Parameters:
- None. All widths are fixed.

Ports:
- CLK  in  1  host Z80 clock; all state is on the rising edge
- RESET_B  in  1  asynchronous, active-low reset
- SEL  in  1  upper-address match: ADR[15:4] == &FC1
- ADR  in  4  host ADR[3:0]; the block responds only when ADR[3]=1
- IOREQ_B, RD_B, WR_B  in  1 each  host bus strobes, active low
- DIN  in  8  host write data
- DOUT  out  8  read data
- DOUT_EN  out  1  high while a read access to this block is active; the top level drives host DATA from DOUT
- PMOD_GPIO  inout  8  PMOD pins
- INT_B  out  1  interrupt to host, active low

## Operation
- Access terms:
  - wr_act = SEL & ADR[3] & !IOREQ_B & !WR_B
  - rd_act = SEL & ADR[3] & !IOREQ_B & !RD_B
- Access strobes: wr_stb / rd_stb fire for exactly one cycle, on the first rising edge where wr_act / rd_act is high and its registered copy is low. Long or wait-stretched cycles therefore act once.
- DOUT/DOUT_EN are combinational from rd_act and the current register contents.
- Register map (by ADR[3:0]):
  - 8 SPI_DATA. Write: load TX byte and start a transfer. Read: last received byte; rd_stb clears DONE.
  - 9 SPI_CTRL.
    - Write fields: [1:0] DIV, [2] SPI_EN, [3] CS (1 drives pin 3 low), [4] IE.
    - Read returns: [7] BUSY, [6] DONE, [5] OVR, [4:0] as written.
    - rd_stb clears OVR.
  - A–D: read 8'h00; writes ignored.
  - E DIR: 1 = output, per pin.
  - F DATA: write sets the output latch; read returns the synchronised pin state (2-flop synchroniser, 2-cycle latency).
- Pin ownership:
  - SPI_EN=0: pin i is driven from the DATA latch when DIR[i]=1, otherwise hi-Z.
  - SPI_EN=1: pins are fixed as 0=SCK, 1=MOSI, 2=MISO (hi-Z, input), 3=CS_B. DIR[3:0] is retained but ignored. Pins 4–7 still follow DIR.
- SPI FSM states: IDLE, LO (SCK low), HI (SCK high).
  - Start condition: IDLE with wr_stb@8 and SPI_EN=1. On start: latch DIV into div_q, shift_q <= DIN, bit counter = 0, BUSY=1, go to LO.
  - Half-period = 2^div_q CLK cycles.
  - LO→HI at the end of each half-period: SCK rises and MISO (raw pin, unsynchronised) is sampled into rx_q LSB.
  - HI→LO at the end of each half-period: SCK falls, shift_q shifts left, and the bit counter increments.
  - On the 8th falling edge: go to IDLE, BUSY=0, DONE=1, SPI_DATA read value <= rx_q.
  - MOSI = shift_q[7] at all times (holds the last value in IDLE).
  - wr_stb@8 with SPI_EN=0 is ignored.
- INT_B = !(DONE & IE).
- Boundary conditions:
  - wr_stb@8 while BUSY: the write is ignored and OVR=1 (sticky). The transfer in flight is unaffected.
  - DONE set and rd_stb@8 clear in the same cycle: set wins.
  - OVR set and rd_stb@9 clear in the same cycle: set wins.
  - Write to DIV while BUSY: stored in the register, but takes effect on the next transfer only.
  - SPI_EN cleared while BUSY: immediate abort to IDLE, SCK=0, BUSY=0. DONE and the SPI_DATA read value are unchanged.
  - RESET_B low at any time, including mid-transfer: everything returns to reset values asynchronously.
- Reset values:
  - Registers and flags: DIR=00, DATA latch=00, SPI_CTRL=00, BUSY/DONE/OVR=0, SPI_DATA read=00.
  - FSM: IDLE, SCK=0, MOSI=0.
  - Outputs: PMOD_GPIO all hi-Z, INT_B=1, DOUT_EN=0.

## Timing
- Register write: visible on pins and in read-back 1 cycle after wr_stb.
- SPI start: first SCK rise occurs 2^DIV cycles after the BUSY rising edge.
- Total BUSY duration: 16·2^DIV cycles. DIV=0 gives 16 cycles; DIV=3 gives 128 cycles.
- DONE and INT_B assert on the same edge that BUSY falls.
- GPIO input path: a pin change appears in a DATA read 2 cycles later.

## Structure
- Shared package z80tube_pkg holds:
  - register offsets (8, 9, E, F)
  - SPI_CTRL bit positions
  - the FSM state encoding
- Sub-module pmod_spi_engine contains the FSM, divider, bit counter and shift registers. Its interface: start, din, div, abort → busy, done_pulse, rx, sck, mosi; plus miso input.
- pmod_port contains the strobe edge-detect, registers, pin muxing and read mux.

## Test plan
- Reset with all pins pulled up → PMOD_GPIO hi-Z, INT_B=1, read @9 = 00, read @F = FF.
- Write DIR=0F and DATA=A5 → pins[3:0]=0101, pins[7:4] hi-Z; read @E = 0F.
- SPI_CTRL=14 (SPI_EN=1, IE=1, DIV=0), write @8 = 3C with MISO looped to MOSI:
  - BUSY for 16 cycles, 8 SCK pulses, MOSI sequence 00111100.
  - Then read @8 = 3C.
  - INT_B low until that read.
- Second write @8 during BUSY → OVR=1, transfer still returns the first byte, read @9 shows bit 5 set; a second read @9 shows it clear.
- DIV=3 transfer → BUSY for 128 cycles.
- Clearing SPI_EN at cycle 40 → SCK=0, BUSY=0, DONE stays 0.
- Assert RESET_B mid-transfer and hold WR_B low across 3 wait cycles → no double write; all state returns to reset values immediately.
